// File: rtl/boxhead_blit_pkg.sv
// -----------------------------------------------------------------------------
// boxhead_blit_pkg
// Shared types and defaults for the sprite blit sequencer.
//   blit_cmd_t  : one rectangular copy command as queued in the command FIFO
//   state_t     : sequencer FSM state
//   pix_meta_t  : per-pixel side information travelling with an SRAM read
// -----------------------------------------------------------------------------
package boxhead_blit_pkg;

    localparam int unsigned    DEF_FIFO_DEPTH  = 8;
    localparam logic [15:0]    DEF_TRANSPARENT = 16'hF81F;
    localparam int unsigned    DEF_SCREEN_W    = 640;
    localparam int unsigned    DEF_SCREEN_H    = 480;

    typedef struct packed {
        logic [19:0] src_base;
        logic [9:0]  x;
        logic [9:0]  y;
        logic [9:0]  w;
        logic [9:0]  h;
        logic [1:0]  palette;
    } blit_cmd_t;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    // Destination coordinates are carried at 11 bits so that x+col / y+row
    // never wrap back onto the screen before the clip compare.
    typedef struct packed {
        logic        valid;
        logic [10:0] x;
        logic [10:0] y;
        logic [1:0]  palette;
    } pix_meta_t;

endpackage

// File: rtl/blit_cmd_fifo.sv
// -----------------------------------------------------------------------------
// blit_cmd_fifo
// Synchronous FIFO of blit commands with first-word fall-through head.
//   clk, reset     : clock, asynchronous active-high reset (empties the FIFO)
//   push_i         : write push_data_i when not full (refused when full, even
//                    if a pop happens in the same cycle)
//   pop_i          : drop head_o when not empty
//   head_o         : oldest entry, valid while empty_o is low
//   full_o/empty_o : derived from registered occupancy only
// -----------------------------------------------------------------------------
module blit_cmd_fifo
    import boxhead_blit_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_FIFO_DEPTH
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      push_i,
    input  blit_cmd_t push_data_i,
    input  logic      pop_i,
    output blit_cmd_t head_o,
    output logic      full_o,
    output logic      empty_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    blit_cmd_t        mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic [PTR_W:0]   count_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_ptr_q];

    // NOTE: every variable assigned in always_comb gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        count_d = count_q;
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: the storage array has no reset; an entry is only ever read after
    // count_q says it was written, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            // DEPTH is a power of two, so pointers wrap by natural overflow.
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/blit_sequencer.sv
// -----------------------------------------------------------------------------
// blit_sequencer
// Pops rectangular blit commands, walks source SRAM addresses row-major and
// emits one frame-buffer write per visible, non-transparent pixel.
//   clk, reset        : clock, asynchronous active-high reset (aborts work)
//   cmd_*             : command offer; accepted on cmd_valid & cmd_ready
//   src_addr/src_data : SRAM read port, data valid 1 clk after the address
//   program_*         : registered frame-buffer write, 1-clk program_write
//   palette_index     : palette of the write, aligned with program_write
//   current_frame     : displayed-buffer select from the VGA clock domain
//   busy              : queued or in-flight work exists
//   frame_overrun     : 1-clk pulse when current_frame toggles while busy
// -----------------------------------------------------------------------------
module blit_sequencer
    import boxhead_blit_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH  = DEF_FIFO_DEPTH,
    parameter logic [15:0] TRANSPARENT = DEF_TRANSPARENT,
    parameter int unsigned SCREEN_W    = DEF_SCREEN_W,
    parameter int unsigned SCREEN_H    = DEF_SCREEN_H
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [19:0] cmd_src_base,
    input  logic [9:0]  cmd_x,
    input  logic [9:0]  cmd_y,
    input  logic [9:0]  cmd_w,
    input  logic [9:0]  cmd_h,
    input  logic [1:0]  cmd_palette,
    output logic [19:0] src_addr,
    input  logic [15:0] src_data,
    output logic [9:0]  program_x,
    output logic [9:0]  program_y,
    output logic [15:0] program_data,
    output logic        program_write,
    output logic [1:0]  palette_index,
    input  logic        current_frame,
    output logic        busy,
    output logic        frame_overrun
);

    blit_cmd_t   push_cmd;
    blit_cmd_t   head_cmd;
    logic        fifo_full;
    logic        fifo_empty;
    logic        fifo_pop;

    state_t      state_q;
    logic [9:0]  x_q, y_q, w_q, h_q;
    logic [1:0]  pal_q;
    logic [9:0]  col_q, row_q;
    logic [19:0] addr_q;
    logic [19:0] src_addr_q;
    pix_meta_t   pipe1_q, pipe2_q;

    logic [9:0]  prog_x_q, prog_y_q;
    logic [15:0] prog_data_q;
    logic        prog_write_q;
    logic [1:0]  prog_pal_q;
    logic        busy_q;
    logic [2:0]  frame_sync_q;
    logic        overrun_q;

    logic [10:0] pix_x_d, pix_y_d;
    logic        last_col_d, last_row_d;
    logic        write_en_d;
    logic        busy_d;

    assign push_cmd = '{src_base: cmd_src_base, x: cmd_x, y: cmd_y,
                        w: cmd_w, h: cmd_h, palette: cmd_palette};

    // The FIFO is popped in the same cycle IDLE sees it non-empty.
    assign fifo_pop  = (state_q == IDLE) && !fifo_empty;
    assign cmd_ready = !fifo_full;

    blit_cmd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (cmd_valid),
        .push_data_i (push_cmd),
        .pop_i       (fifo_pop),
        .head_o      (head_cmd),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    assign pix_x_d    = {1'b0, x_q} + {1'b0, col_q};
    assign pix_y_d    = {1'b0, y_q} + {1'b0, row_q};
    assign last_col_d = (col_q == w_q - 10'd1);
    assign last_row_d = (row_q == h_q - 10'd1);

    // Command sequencer: latches a command in IDLE and issues one read per clk
    // in RUN, tagging each read with its own coordinates and palette.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            x_q        <= '0;
            y_q        <= '0;
            w_q        <= '0;
            h_q        <= '0;
            pal_q      <= '0;
            col_q      <= '0;
            row_q      <= '0;
            addr_q     <= '0;
            src_addr_q <= '0;
            pipe1_q    <= '0;
        end else begin
            pipe1_q.valid <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (!fifo_empty) begin
                        x_q    <= head_cmd.x;
                        y_q    <= head_cmd.y;
                        w_q    <= head_cmd.w;
                        h_q    <= head_cmd.h;
                        pal_q  <= head_cmd.palette;
                        col_q  <= '0;
                        row_q  <= '0;
                        addr_q <= head_cmd.src_base;
                        // Empty rectangles are consumed without any read.
                        if (head_cmd.w != '0 && head_cmd.h != '0) begin
                            state_q <= RUN;
                        end
                    end
                end
                RUN: begin
                    src_addr_q <= addr_q;
                    pipe1_q    <= '{valid: 1'b1, x: pix_x_d, y: pix_y_d,
                                    palette: pal_q};
                    addr_q     <= addr_q + 20'd1;
                    if (last_col_d) begin
                        col_q <= '0;
                        row_q <= row_q + 10'd1;
                        if (last_row_d) begin
                            state_q <= IDLE;
                        end
                    end else begin
                        col_q <= col_q + 10'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // pipe1 lines up with the registered address, pipe2 with the SRAM data.
    assign write_en_d = pipe2_q.valid && (src_data != TRANSPARENT) &&
                        (pipe2_q.x < 11'(SCREEN_W)) && (pipe2_q.y < 11'(SCREEN_H));

    assign busy_d = !fifo_empty || (state_q != IDLE) || pipe1_q.valid || pipe2_q.valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pipe2_q      <= '0;
            prog_x_q     <= '0;
            prog_y_q     <= '0;
            prog_data_q  <= '0;
            prog_write_q <= 1'b0;
            prog_pal_q   <= '0;
            busy_q       <= 1'b0;
        end else begin
            pipe2_q      <= pipe1_q;
            prog_x_q     <= pipe2_q.x[9:0];
            prog_y_q     <= pipe2_q.y[9:0];
            prog_data_q  <= src_data;
            prog_pal_q   <= pipe2_q.palette;
            prog_write_q <= write_en_d;
            busy_q       <= busy_d;
        end
    end

    // current_frame is asynchronous: two flops resynchronise it, the third
    // holds the previous value so either edge can be detected.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_sync_q <= '0;
            overrun_q    <= 1'b0;
        end else begin
            frame_sync_q <= {frame_sync_q[1:0], current_frame};
            overrun_q    <= (frame_sync_q[2] ^ frame_sync_q[1]) && busy_q;
        end
    end

    assign src_addr      = src_addr_q;
    assign program_x     = prog_x_q;
    assign program_y     = prog_y_q;
    assign program_data  = prog_data_q;
    assign program_write = prog_write_q;
    assign palette_index = prog_pal_q;
    assign busy          = busy_q;
    assign frame_overrun = overrun_q;

endmodule

// File: tb/tb_blit_sequencer.sv
`timescale 1ns/1ps
module tb_blit_sequencer;

    localparam logic [15:0] TRANSP = 16'hF81F;
    localparam int          SCR_W  = 640;
    localparam int          SCR_H  = 480;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [19:0] cmd_src_base;
    logic [9:0]  cmd_x, cmd_y, cmd_w, cmd_h;
    logic [1:0]  cmd_palette;
    logic [19:0] src_addr;
    logic [15:0] src_data = 16'h0000;
    logic [9:0]  program_x, program_y;
    logic [15:0] program_data;
    logic        program_write;
    logic [1:0]  palette_index;
    logic        current_frame;
    logic        busy;
    logic        frame_overrun;

    int n_cmp = 0;
    int n_err = 0;
    int wr_cnt = 0;
    int ovr_cnt = 0;

    // Expected writes, in issue order: {x, y, data, palette}.
    logic [37:0] exp_q [$];
    logic [37:0] exp_pix;

    logic [19:0] transp_addr;
    logic        transp_mask_en;

    always #5 clk = ~clk;

    blit_sequencer #(
        .FIFO_DEPTH  (8),
        .TRANSPARENT (16'hF81F),
        .SCREEN_W    (640),
        .SCREEN_H    (480)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_src_base  (cmd_src_base),
        .cmd_x         (cmd_x),
        .cmd_y         (cmd_y),
        .cmd_w         (cmd_w),
        .cmd_h         (cmd_h),
        .cmd_palette   (cmd_palette),
        .src_addr      (src_addr),
        .src_data      (src_data),
        .program_x     (program_x),
        .program_y     (program_y),
        .program_data  (program_data),
        .program_write (program_write),
        .palette_index (palette_index),
        .current_frame (current_frame),
        .busy          (busy),
        .frame_overrun (frame_overrun)
    );

    // SRAM contents: a fixed scramble of the address, transparent only where
    // the bench chooses.
    function automatic logic [15:0] sram_word(input logic [19:0] a);
        logic [15:0] h;
        if (a == transp_addr || (transp_mask_en && a[2:0] == 3'd5)) return TRANSP;
        h = a[15:0] ^ {a[19:16], a[11:0]} ^ 16'h3C5A;
        if (h == TRANSP) h = h ^ 16'h0001;
        return h;
    endfunction

    always @(posedge clk) src_data <= sram_word(src_addr);

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: enumerate the rectangle and keep visible, opaque pixels.
    task automatic model_cmd(input logic [19:0] base, input logic [9:0] x, input logic [9:0] y,
                             input logic [9:0] w, input logic [9:0] h, input logic [1:0] pal);
        for (int r = 0; r < int'(h); r++) begin
            for (int c = 0; c < int'(w); c++) begin
                int ax;
                int ay;
                logic [19:0] a;
                logic [15:0] d;
                ax = int'(x) + c;
                ay = int'(y) + r;
                a  = base + 20'(r * int'(w) + c);
                d  = sram_word(a);
                if (d != TRANSP && ax < SCR_W && ay < SCR_H)
                    exp_q.push_back({10'(ax), 10'(ay), d, pal});
            end
        end
    endtask

    task automatic drive_cmd(input logic [19:0] base, input logic [9:0] x, input logic [9:0] y,
                             input logic [9:0] w, input logic [9:0] h, input logic [1:0] pal);
        cmd_src_base = base;
        cmd_x        = x;
        cmd_y        = y;
        cmd_w        = w;
        cmd_h        = h;
        cmd_palette  = pal;
        cmd_valid    = 1'b1;
    endtask

    // Called right after a negedge; returns right after the accepting edge.
    task automatic push_cmd(input logic [19:0] base, input logic [9:0] x, input logic [9:0] y,
                            input logic [9:0] w, input logic [9:0] h, input logic [1:0] pal);
        int   budget = 2000;
        logic acc = 1'b0;
        drive_cmd(base, x, y, w, h, pal);
        while (!acc && budget > 0) begin
            acc = cmd_ready;
            @(negedge clk);
            budget--;
        end
        cmd_valid = 1'b0;
        check("push_accepted", 64'(acc), 64'(1));
        if (acc) model_cmd(base, x, y, w, h, pal);
    endtask

    task automatic wait_addr(input logic [19:0] a, input string tag);
        int budget = 400;
        while (src_addr !== a && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check(tag, 64'(src_addr), 64'(a));
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int left = budget;
        repeat (2) @(negedge clk);
        while (busy !== 1'b0 && left > 0) begin
            @(negedge clk);
            left--;
        end
        check(tag, 64'(busy), 64'(0));
        check({tag, "_drained"}, 64'(exp_q.size()), 64'(0));
    endtask

    // Write monitor: every strobe must match the next modelled pixel.
    always @(negedge clk) begin
        if (!reset) begin
            if (frame_overrun) ovr_cnt++;
            if (program_write) begin
                wr_cnt++;
                check("busy_during_write", 64'(busy), 64'(1));
                check("write_expected", 64'(exp_q.size() != 0), 64'(1));
                if (exp_q.size() != 0) begin
                    exp_pix = exp_q.pop_front();
                    check("write_pixel", 64'({program_x, program_y, program_data, palette_index}),
                          64'(exp_pix));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int wr0;
        int ovr0;
        reset          = 1'b1;
        cmd_valid      = 1'b0;
        cmd_src_base   = '0;
        cmd_x          = '0;
        cmd_y          = '0;
        cmd_w          = '0;
        cmd_h          = '0;
        cmd_palette    = '0;
        current_frame  = 1'b0;
        transp_addr    = 20'h7FFFF;
        transp_mask_en = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", 64'(cmd_ready), 64'(1));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_write", 64'(program_write), 64'(0));
        check("rst_overrun", 64'(frame_overrun), 64'(0));
        check("rst_outputs", 64'({src_addr, program_x, program_y, program_data, palette_index}), 64'(0));
        reset = 1'b0;
        @(negedge clk);

        // Single 2x2 blit: address walk and 2-clk write latency
        push_cmd(20'h00100, 10'd10, 10'd20, 10'd2, 10'd2, 2'd1);
        wait_addr(20'h00100, "b1_addr0");
        @(negedge clk);
        check("b1_addr1", 64'(src_addr), 64'(20'h00101));
        @(negedge clk);
        check("b1_addr2", 64'(src_addr), 64'(20'h00102));
        check("b1_first_write", 64'({program_write, program_x, program_y, palette_index}),
              64'({1'b1, 10'd10, 10'd20, 2'd1}));
        @(negedge clk);
        check("b1_addr3", 64'(src_addr), 64'(20'h00103));
        wait_idle(50, "b1_idle");

        // Transparency: word 0x102 is skipped, all four reads still issued
        transp_addr = 20'h00102;
        wr0 = wr_cnt;
        push_cmd(20'h00100, 10'd100, 10'd50, 10'd4, 10'd1, 2'd2);
        wait_addr(20'h00100, "tr_addr0");
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            check("tr_addr_walk", 64'(src_addr), 64'(20'h00100 + 20'(i)));
        end
        wait_idle(50, "tr_idle");
        check("tr_write_count", 64'(wr_cnt - wr0), 64'(3));

        // Clipping at the bottom-right corner
        wr0 = wr_cnt;
        push_cmd(20'h00200, 10'd638, 10'd479, 10'd4, 10'd2, 2'd3);
        wait_addr(20'h00200, "clip_addr0");
        for (int i = 1; i < 8; i++) begin
            @(negedge clk);
            check("clip_addr_walk", 64'(src_addr), 64'(20'h00200 + 20'(i)));
        end
        wait_idle(50, "clip_idle");
        check("clip_write_count", 64'(wr_cnt - wr0), 64'(2));

        // No-op commands: consumed in one clk with no reads
        push_cmd(20'hABCDE, 10'd5, 10'd5, 10'd0, 10'd7, 2'd1);
        @(negedge clk);
        check("noop_busy_pulse", 64'(busy), 64'(1));
        @(negedge clk);
        check("noop_idle", 64'(busy), 64'(0));
        check("noop_no_read", 64'(src_addr), 64'(20'h00207));
        push_cmd(20'hABCDE, 10'd5, 10'd5, 10'd5, 10'd0, 2'd1);
        wait_idle(10, "noop_h0_idle");
        check("noop_h0_no_read", 64'(src_addr), 64'(20'h00207));

        // FIFO full while a long blit runs
        push_cmd(20'h02000, 10'd0, 10'd100, 10'd60, 10'd4, 2'd3);
        wait_addr(20'h02000, "fifo_long_start");
        for (int i = 0; i < 8; i++) begin
            check("fifo_ready_before_push", 64'(cmd_ready), 64'(1));
            push_cmd(20'h02100 + 20'(i * 8), 10'(20 * i), 10'd200,
                     (i == 3) ? 10'd0 : 10'd2, 10'd2, 2'(i));
        end
        check("fifo_full_ready_low", 64'(cmd_ready), 64'(0));
        drive_cmd(20'h02200, 10'd300, 10'd300, 10'd1, 10'd1, 2'd2);
        repeat (5) begin
            @(negedge clk);
            check("fifo_ninth_held", 64'(cmd_ready), 64'(0));
        end
        push_cmd(20'h02200, 10'd300, 10'd300, 10'd1, 10'd1, 2'd2);
        wait_idle(1500, "fifo_drain");

        // Address wrap and back-to-back palettes
        push_cmd(20'hFFFFE, 10'd0, 10'd0, 10'd4, 10'd1, 2'd0);
        push_cmd(20'h00300, 10'd5, 10'd5, 10'd3, 10'd1, 2'd2);
        wait_addr(20'hFFFFE, "wrap_addr0");
        @(negedge clk);
        check("wrap_addr1", 64'(src_addr), 64'(20'hFFFFF));
        @(negedge clk);
        check("wrap_addr2", 64'(src_addr), 64'(20'h00000));
        @(negedge clk);
        check("wrap_addr3", 64'(src_addr), 64'(20'h00001));
        repeat (2) @(negedge clk);
        check("b2b_next_addr", 64'(src_addr), 64'(20'h00300));
        wait_idle(50, "wrap_idle");

        // Frame overrun: pulse while busy, silence while idle
        push_cmd(20'h03000, 10'd0, 10'd0, 10'd40, 10'd2, 2'd1);
        wait_addr(20'h03000, "ovr_start");
        ovr0 = ovr_cnt;
        current_frame = ~current_frame;
        repeat (8) @(negedge clk);
        check("ovr_busy_pulse", 64'(ovr_cnt - ovr0), 64'(1));
        wait_idle(200, "ovr_idle");
        ovr0 = ovr_cnt;
        current_frame = ~current_frame;
        repeat (8) @(negedge clk);
        check("ovr_idle_none", 64'(ovr_cnt - ovr0), 64'(0));

        // Randomized commands with some transparent words
        transp_mask_en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            logic [9:0] rx;
            logic [9:0] ry;
            repeat ($urandom_range(0, 3)) @(negedge clk);
            rx = ($urandom_range(0, 1) == 0) ? 10'($urandom_range(0, 639)) : 10'($urandom_range(630, 1023));
            ry = ($urandom_range(0, 1) == 0) ? 10'($urandom_range(0, 479)) : 10'($urandom_range(470, 1023));
            push_cmd(20'h00400 + 20'($urandom_range(0, 255)), rx, ry,
                     10'($urandom_range(0, 6)), 10'($urandom_range(0, 4)), 2'($urandom_range(0, 3)));
        end
        wait_idle(3000, "rand_idle");
        transp_mask_en = 1'b0;

        // Reset mid-RUN aborts the blit and drops queued commands
        push_cmd(20'h05000, 10'd0, 10'd0, 10'd50, 10'd3, 2'd1);
        push_cmd(20'h06000, 10'd1, 10'd1, 10'd3, 10'd3, 2'd2);
        push_cmd(20'h07000, 10'd2, 10'd2, 10'd3, 10'd3, 2'd3);
        wait_addr(20'h05004, "rst_mid_run");
        #2 reset = 1'b1;
        #1;
        check("rst_mid_write", 64'(program_write), 64'(0));
        check("rst_mid_busy", 64'(busy), 64'(0));
        check("rst_mid_ready", 64'(cmd_ready), 64'(1));
        check("rst_mid_addr", 64'(src_addr), 64'(0));
        exp_q.delete();
        repeat (2) begin
            @(negedge clk);
            check("rst_hold_write", 64'(program_write), 64'(0));
        end
        reset = 1'b0;
        wr0 = wr_cnt;
        repeat (30) @(negedge clk);
        check("rst_no_writes_after", 64'(wr_cnt - wr0), 64'(0));
        check("rst_after_busy", 64'(busy), 64'(0));
        check("rst_after_ready", 64'(cmd_ready), 64'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
